// File: rtl/arb_pkg.sv
// Shared definitions for the data-memory port arbiter.
//   MODE_RR / MODE_FIXED : accepted values of the arbiter MODE parameter
//   arb_state_t          : ownership FSM encoding
//   clog2 / idx_width    : requester index width, never narrower than 1 bit
package arb_pkg;

  localparam string MODE_RR    = "RR";
  localparam string MODE_FIXED = "FIXED";

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int idx_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational picker: first set request at or above the start pointer,
// wrapping to index 0. With FIXED set the pointer is ignored and the lowest
// set index wins.
//   req : request vector
//   ptr : search start index
//   gnt : one-hot winner (0 when no request)
//   idx : winner index (0 when no request)
//   any : at least one request present
module rr_pick
  import arb_pkg::*;
#(
  parameter int  NREQ  = 2,
  parameter bit  FIXED = 1'b0,
  localparam int IW    = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            any
);

  logic [IW-1:0]     start;
  logic [2*NREQ-1:0] dbl;
  logic              found;

  // Lower half holds requests at or above the pointer, upper half the full
  // vector; the lowest set bit of the pair is the wrapped round-robin winner.
  always_comb begin
    start = FIXED ? '0 : ptr;
    dbl   = {req, req};
    for (int i = 0; i < NREQ; i++) begin
      if (i < int'(start)) dbl[i] = 1'b0;
    end
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < 2*NREQ; i++) begin
      if (dbl[i] && !found) begin
        found = 1'b1;
        idx   = (i >= NREQ) ? IW'(i - NREQ) : IW'(i);
      end
    end
    gnt = found ? (NREQ'(1) << idx) : '0;
  end

  assign any = |req;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates NREQ requesters onto the single data-memory port, with optional
// bus lock for multi-beat bursts and read-return routing after RD_LAT cycles.
//   clk, rst               : clock, synchronous active-low reset
//   i_req/i_we/i_lock      : per-requester request, write select, lock
//   i_addr/i_wdata         : packed per-requester address / write data
//   o_gnt/o_stall          : one-hot grant (same cycle) and req & ~gnt
//   o_rvalid/o_rdata       : one-hot read-return strobe and read data
//   o_memaddr/o_write_en/o_read_en/o_write_data/i_read_data : memory port
//
// state  | meaning
// IDLE   | normal arbitration from ptr (RR) or by index (FIXED)
// LOCKED | owner keeps the port while it requests with i_lock set
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int    NREQ   = 2,
  parameter int    AW     = 32,
  parameter int    DW     = 32,
  parameter string MODE   = "RR",
  parameter int    RD_LAT = 1,
  localparam int   IW     = idx_width(NREQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    i_req,
  input  logic [NREQ-1:0]    i_we,
  input  logic [NREQ-1:0]    i_lock,
  input  logic [NREQ*AW-1:0] i_addr,
  input  logic [NREQ*DW-1:0] i_wdata,
  output logic [NREQ-1:0]    o_gnt,
  output logic [NREQ-1:0]    o_stall,
  output logic [NREQ-1:0]    o_rvalid,
  output logic [DW-1:0]      o_rdata,
  output logic [AW-1:0]      o_memaddr,
  output logic               o_write_en,
  output logic               o_read_en,
  output logic [DW-1:0]      o_write_data,
  input  logic [DW-1:0]      i_read_data
);

  localparam bit IS_RR    = (MODE == MODE_RR);
  localparam bit IS_FIXED = (MODE == MODE_FIXED);

  arb_state_t      state;
  logic [IW-1:0]   owner;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   eff_ptr;
  logic [IW-1:0]   win;
  logic [IW-1:0]   pick_idx;
  logic [NREQ-1:0] pick_gnt;
  logic [NREQ-1:0] gnt_raw;
  logic            pick_any;
  logic            hold;
  logic            granted;
  logic            win_we;

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] x);
    return (int'(x) >= NREQ - 1) ? '0 : x + IW'(1);
  endfunction

  // A locked owner that drops request or lock releases in the same cycle;
  // that cycle arbitrates as IDLE starting just past the owner.
  always_comb begin
    hold    = (state == LOCKED) && i_req[owner] && i_lock[owner];
    eff_ptr = (state == LOCKED) ? next_idx(owner) : ptr;
  end

  // Unrecognised mode strings fall back to fixed priority.
  rr_pick #(
    .NREQ  (NREQ),
    .FIXED (IS_FIXED || !IS_RR)
  ) u_pick (
    .req (i_req),
    .ptr (eff_ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_comb begin
    win          = hold ? owner : pick_idx;
    granted      = rst && (hold || pick_any);
    gnt_raw      = hold ? (NREQ'(1) << owner) : pick_gnt;
    o_gnt        = granted ? gnt_raw : '0;
    o_stall      = i_req & ~o_gnt;
    win_we       = i_we[win];
    o_write_en   = granted && win_we;
    o_read_en    = granted && !win_we;
    o_memaddr    = granted ? i_addr[int'(win)*AW +: AW] : '0;
    o_write_data = granted ? i_wdata[int'(win)*DW +: DW] : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      owner <= '0;
      ptr   <= '0;
    end else if (!hold) begin
      ptr <= pick_any ? next_idx(pick_idx) : eff_ptr;
      if (pick_any && i_lock[pick_idx]) begin
        state <= LOCKED;
        owner <= pick_idx;
      end else begin
        state <= IDLE;
      end
    end
  end

  assign o_rdata = i_read_data;

  generate
    if (RD_LAT == 0) begin : g_lat0
      assign o_rvalid = o_read_en ? o_gnt : '0;
    end else begin : g_pipe
      logic [RD_LAT-1:0] pv;
      logic [IW-1:0]     pidx [RD_LAT];

      always_ff @(posedge clk) begin
        if (!rst) begin
          pv <= '0;
          for (int i = 0; i < RD_LAT; i++) pidx[i] <= '0;
        end else begin
          pv[0]   <= o_read_en;
          pidx[0] <= win;
          for (int i = 1; i < RD_LAT; i++) begin
            pv[i]   <= pv[i-1];
            pidx[i] <= pidx[i-1];
          end
        end
      end

      assign o_rvalid = (rst && pv[RD_LAT-1]) ? (NREQ'(1) << pidx[RD_LAT-1]) : '0;
    end
  endgenerate

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_run  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // A: RR, 3 requesters, latency 1
  logic [2:0]  a_req, a_we, a_lock, a_gnt, a_stall, a_rvalid;
  logic [95:0] a_addr, a_wdata;
  logic [31:0] a_rdata, a_memaddr, a_wdo, a_rdi;
  logic        a_wen, a_ren;
  // B: FIXED, 3 requesters, latency 1
  logic [2:0]  b_req, b_we, b_lock, b_gnt, b_stall, b_rvalid;
  logic [95:0] b_addr, b_wdata;
  logic [31:0] b_rdata, b_memaddr, b_wdo, b_rdi;
  logic        b_wen, b_ren;
  // C: RR, 2 requesters, latency 3
  logic [1:0]  c_req, c_we, c_lock, c_gnt, c_stall, c_rvalid;
  logic [63:0] c_addr, c_wdata;
  logic [31:0] c_rdata, c_memaddr, c_wdo, c_rdi;
  logic        c_wen, c_ren;
  // D: RR, 2 requesters, latency 2
  logic [1:0]  d_req, d_we, d_lock, d_gnt, d_stall, d_rvalid;
  logic [63:0] d_addr, d_wdata;
  logic [31:0] d_rdata, d_memaddr, d_wdo, d_rdi;
  logic        d_wen, d_ren;

  mem_port_arbiter #(.NREQ(3), .MODE("RR"), .RD_LAT(1)) u_a (
    .clk(clk), .rst(rst), .i_req(a_req), .i_we(a_we), .i_lock(a_lock),
    .i_addr(a_addr), .i_wdata(a_wdata), .o_gnt(a_gnt), .o_stall(a_stall),
    .o_rvalid(a_rvalid), .o_rdata(a_rdata), .o_memaddr(a_memaddr),
    .o_write_en(a_wen), .o_read_en(a_ren), .o_write_data(a_wdo), .i_read_data(a_rdi));

  mem_port_arbiter #(.NREQ(3), .MODE("FIXED"), .RD_LAT(1)) u_b (
    .clk(clk), .rst(rst), .i_req(b_req), .i_we(b_we), .i_lock(b_lock),
    .i_addr(b_addr), .i_wdata(b_wdata), .o_gnt(b_gnt), .o_stall(b_stall),
    .o_rvalid(b_rvalid), .o_rdata(b_rdata), .o_memaddr(b_memaddr),
    .o_write_en(b_wen), .o_read_en(b_ren), .o_write_data(b_wdo), .i_read_data(b_rdi));

  mem_port_arbiter #(.NREQ(2), .MODE("RR"), .RD_LAT(3)) u_c (
    .clk(clk), .rst(rst), .i_req(c_req), .i_we(c_we), .i_lock(c_lock),
    .i_addr(c_addr), .i_wdata(c_wdata), .o_gnt(c_gnt), .o_stall(c_stall),
    .o_rvalid(c_rvalid), .o_rdata(c_rdata), .o_memaddr(c_memaddr),
    .o_write_en(c_wen), .o_read_en(c_ren), .o_write_data(c_wdo), .i_read_data(c_rdi));

  mem_port_arbiter #(.NREQ(2), .MODE("RR"), .RD_LAT(2)) u_d (
    .clk(clk), .rst(rst), .i_req(d_req), .i_we(d_we), .i_lock(d_lock),
    .i_addr(d_addr), .i_wdata(d_wdata), .o_gnt(d_gnt), .o_stall(d_stall),
    .o_rvalid(d_rvalid), .o_rdata(d_rdata), .o_memaddr(d_memaddr),
    .o_write_en(d_wen), .o_read_en(d_ren), .o_write_data(d_wdo), .i_read_data(d_rdi));

  logic [2:0] rr_exp [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
  logic [1:0] c_req_tbl [7] = '{2'b01, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
  logic [1:0] c_rv_tbl  [7] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b01, 2'b00};
  logic [1:0] w_req_tbl [6] = '{2'b01, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00};
  logic [1:0] w_we_tbl  [6] = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
  logic [1:0] w_rv_tbl  [6] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [2:0] prev;
    a_req = '0; a_we = '0; a_lock = '0; a_wdata = '0; a_rdi = '0;
    b_req = '0; b_we = '0; b_lock = '0; b_wdata = '0; b_rdi = '0; b_addr = '0;
    c_req = '0; c_we = '0; c_lock = '0; c_wdata = '0; c_rdi = '0;
    d_req = '0; d_we = '0; d_lock = '0; d_wdata = '0; d_rdi = '0; d_addr = '0;
    a_addr = {32'h1008, 32'h1004, 32'h1000};
    c_addr = {32'h204, 32'h200};

    // reset: grants and strobes forced low while requests are present
    rst = 1'b0; a_req = 3'b111; d_req = 2'b11;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check("rst_gnt_a",   a_gnt,    3'b000);
    check("rst_stall_a", a_stall,  3'b111);
    check("rst_ren_a",   a_ren,    1'b0);
    check("rst_rv_a",    a_rvalid, 3'b000);
    check("rst_gnt_d",   d_gnt,    2'b00);
    d_req = '0;

    // round-robin rotation, reads returning one cycle later
    prev = '0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      rst = 1'b1; a_req = 3'b111; a_rdi = 32'h5000 + c;
      #1;
      check($sformatf("rr_gnt%0d", c), a_gnt, rr_exp[c]);
      check($sformatf("rr_rv%0d", c), a_rvalid, prev);
      check($sformatf("rr_addr%0d", c), a_memaddr, 32'h1000 + 4*(c % 3));
      check($sformatf("rr_rdata%0d", c), a_rdata, 32'h5000 + c);
      prev = rr_exp[c];
    end

    // move ptr to 1, then lock requester 1 against a pending requester 0
    @(negedge clk); a_req = 3'b001; #1;
    check("rr_gnt6", a_gnt, 3'b001);
    check("rr_rv6", a_rvalid, 3'b100);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a_req = 3'b011; a_lock = 3'b010;
      a_addr[63:32] = 32'h100 + 32'(4*i);
      #1;
      check($sformatf("lock_gnt%0d", i), a_gnt, 3'b010);
      check($sformatf("lock_addr%0d", i), a_memaddr, 32'h100 + 4*i);
      check($sformatf("lock_stall%0d", i), a_stall, 3'b001);
    end
    @(negedge clk); a_req = 3'b001; a_lock = 3'b000; #1;
    check("unlock_gnt", a_gnt, 3'b001);
    @(negedge clk); a_req = '0;

    // fixed priority
    @(negedge clk); b_req = 3'b110; #1;
    check("fx_gnt0", b_gnt, 3'b010);
    check("fx_stall2_0", b_stall[2], 1'b1);
    @(negedge clk); b_req = 3'b111; #1;
    check("fx_gnt1", b_gnt, 3'b001);
    check("fx_stall1", b_stall, 3'b110);
    // lock beats fixed priority
    @(negedge clk); b_req = 3'b010; b_lock = 3'b010; #1;
    check("fx_lock_gnt0", b_gnt, 3'b010);
    @(negedge clk); b_req = 3'b011; #1;
    check("fx_lock_gnt1", b_gnt, 3'b010);
    check("fx_lock_stall", b_stall, 3'b001);
    @(negedge clk); b_req = 3'b001; b_lock = 3'b000; #1;
    check("fx_unlock_gnt", b_gnt, 3'b001);
    @(negedge clk); b_req = '0;

    // latency 3 read return in issue order
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      c_req = c_req_tbl[c]; c_we = '0; c_rdi = 32'hA000 + c;
      #1;
      check($sformatf("l3_gnt%0d", c), c_gnt, c_req_tbl[c]);
      check($sformatf("l3_rv%0d", c), c_rvalid, c_rv_tbl[c]);
      check($sformatf("l3_rdata%0d", c), c_rdata, 32'hA000 + c);
    end

    // write then read: only the read returns
    c_addr[31:0] = 32'h40; c_wdata[31:0] = 32'hDEADBEEF;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      c_req = w_req_tbl[c]; c_we = w_we_tbl[c];
      #1;
      check($sformatf("wr_rv%0d", c), c_rvalid, w_rv_tbl[c]);
      if (c == 0) begin
        check("wr_wen",   c_wen,     1'b1);
        check("wr_ren",   c_ren,     1'b0);
        check("wr_data",  c_wdo,     32'hDEADBEEF);
        check("wr_addr",  c_memaddr, 32'h40);
      end
      if (c == 2) begin
        check("idle_addr", c_memaddr, 32'h0);
        check("idle_wen",  c_wen,     1'b0);
      end
    end

    // reset while a latency-2 read is in flight
    @(negedge clk); d_req = 2'b01; d_lock = 2'b01; #1;
    check("rs_gnt0", d_gnt, 2'b01);
    @(negedge clk); rst = 1'b0; #1;
    check("rs_gnt1", d_gnt, 2'b00);
    check("rs_ren1", d_ren, 1'b0);
    check("rs_rv1",  d_rvalid, 2'b00);
    @(negedge clk); rst = 1'b1; d_req = 2'b00; d_lock = 2'b00; #1;
    check("rs_rv2", d_rvalid, 2'b00);
    @(negedge clk); d_req = 2'b11; #1;
    check("rs_gnt3", d_gnt, 2'b01);
    check("rs_rv3", d_rvalid, 2'b00);
    @(negedge clk); d_req = 2'b00; #1;
    check("rs_rv4", d_rvalid, 2'b00);
    @(negedge clk); #1;
    check("rs_rv5", d_rvalid, 2'b01);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Parametrised successor to the core's two-way scalar/vector data-memory mux. Arbitrates NREQ requesters (scalar MEM stage, vector unit, future DMA/debug) onto the single data-memory port.
- Supports fixed-priority or round-robin mode, bus lock for multi-beat vector bursts, and per-requester read-return routing at a configurable memory read latency.
- Sits between the core's requesters and the o_memaddr/o_write_en/o_read_en/o_write_data/i_read_data port.

Parameters:
- NREQ, 2, number of requesters (1..8); index 0 is highest priority in fixed mode.
- AW, 32, address width.
- DW, 32, data width.
- MODE, "RR", arbitration mode: "RR" (round-robin) or "FIXED".
- RD_LAT, 1, cycles from granted read to valid i_read_data (0..3).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, active-low, synchronous.
- i_req  in  NREQ  per-requester access request; held until granted.
- i_we  in  NREQ  1 = write, 0 = read.
- i_lock  in  NREQ  hold ownership after this grant.
- i_addr  in  NREQ*AW  packed addresses; requester k uses bits [k*AW +: AW].
- i_wdata  in  NREQ*DW  packed write data.
- o_gnt  out  NREQ  one-hot grant, combinational, same cycle as the access.
- o_stall  out  NREQ  i_req & ~o_gnt.
- o_rvalid  out  NREQ  one-hot read-return strobe.
- o_rdata  out  DW  read data; equals i_read_data.
- o_memaddr  out  AW  winner address.
- o_write_en  out  1  winner write strobe.
- o_read_en  out  1  winner read strobe.
- o_write_data  out  DW  winner write data.
- i_read_data  in  DW  memory read data.

Behaviour:
- Reset (rst==0 at posedge):
  - ptr=0, state=IDLE, owner=0; all return-pipe valids cleared.
  - While rst==0, o_gnt, o_rvalid, o_write_en and o_read_en are forced 0.
  - In-flight reads are discarded; no o_rvalid fires for them after reset releases.
- Grant (combinational, zero added latency):
  - At most one bit of o_gnt is set, and only when at least one i_req bit is set.
  - FIXED: the lowest index with i_req set wins.
  - RR: the first index with i_req set, searching from ptr upward and wrapping at NREQ-1 to 0.
- Memory drive:
  - o_memaddr and o_write_data come from the winner slice; both are 0 when there is no grant.
  - o_write_en = gnt & i_we[w]; o_read_en = gnt & ~i_we[w].
- Pointer: on each grant taken in IDLE, ptr <= (w+1) mod NREQ. ptr is unchanged in LOCKED and in idle cycles. ptr is unused in FIXED mode.
- State machine:
  - IDLE -> LOCKED when the winner has i_lock[w]=1; register owner=w.
  - LOCKED: only the owner can be granted. It is granted whenever i_req[owner]=1; other requesters stall even at higher priority.
  - LOCKED -> IDLE, same cycle, when i_req[owner]=0 or i_lock[owner]=0. That cycle arbitrates normally as IDLE, with ptr set to owner+1.
  - LOCKED -> LOCKED while i_req[owner]=1 and i_lock[owner]=1.
  - i_lock on a requester that is not granted has no effect.
- Read return:
  - A shift pipe of depth RD_LAT carries {valid, index} for each granted read.
  - o_rvalid[index] asserts exactly RD_LAT cycles after the read's grant cycle.
  - RD_LAT=0: o_rvalid = o_read_en ? o_gnt : 0, in the same cycle.
  - Writes never produce o_rvalid. Back-to-back reads give back-to-back o_rvalid in issue order.
- Simultaneous events: a new grant and an older read's o_rvalid in the same cycle are independent and both allowed.
- NREQ=1: the grant reduces to i_req[0]; lock has no observable effect.

Decomposition:
- Shared package arb_pkg:
  - MODE string constants "RR" and "FIXED".
  - State encoding IDLE=1'b0, LOCKED=1'b1.
  - clog2 function for index width IW = max(1, clog2(NREQ)).
- One sub-module, rr_pick (parameters NREQ, FIXED):
  - Inputs: request vector and start pointer.
  - Outputs: one-hot grant, winner index, any-valid flag.
  - Purely combinational, implemented as double-width mask-and-priority-encode.
- Top level holds the FSM, ptr, return pipe and output muxes.

Test Plan:
- RR, NREQ=3, RD_LAT=1, i_req=3'b111 held for 6 cycles, all reads -> o_gnt sequence 001,010,100,001,010,100; each o_rvalid matches the previous cycle's o_gnt.
- FIXED, NREQ=3, i_req=3'b110 then 3'b111 -> grants 010, then 001; req2 stalls (o_stall[2]=1) in both cycles.
- Lock: req1 reads 0x100..0x10C with i_lock=1 for 4 cycles while req0 is asserted -> o_gnt=010 for 4 cycles. On cycle 5, i_lock[1]=0 with i_req[1]=0 -> req0 is granted that same cycle.
- RD_LAT=3, reads issued at cycles 0, 1, 2 by req0, req1, req0 -> o_rvalid=01 at cycle 3, 10 at cycle 4, 01 at cycle 5; o_rdata equals i_read_data in each.
- Write plus read mix: req0 writes 0xDEADBEEF to 0x40 -> o_write_en=1, o_write_data=0xDEADBEEF, o_memaddr=0x40, and no o_rvalid follows.
- Reset mid-operation: with RD_LAT=2, assert rst=0 the cycle after a granted read -> o_rvalid stays 0 through and after reset; ptr=0 and state=IDLE on release.
